// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake plus serial line of the UART transmitter.
//   master: the byte producer (drives tx_data/tx_start, watches busy/done/line)
//   slave : the transmitter itself
interface uart_tx_if;
  logic [7:0] tx_data;   // byte to send, sampled on the accept edge only
  logic       tx_start;  // level request, honoured only while idle
  logic       dout;      // serial line, idle high
  logic       tx_busy;   // accept edge .. end of last stop bit
  logic       tx_done;   // one-cycle pulse at frame completion

  modport master (
    output tx_data, tx_start,
    input  dout, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_start,
    output dout, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: oversampled serial transmitter, 8N1 by default.
//   Frame: start bit, DATA_BITS data bits LSB-first, optional parity bit,
//   STOP_BITS stop bits; every bit held for OVERSAMPLE baud_clk cycles.
//   Optional feature macro: UART_TX_PARITY_EN inserts a parity bit
//   (even when PARITY_ODD=0, odd when PARITY_ODD=1) between data and stop.
//   All outputs are flop outputs, so the line never glitches.
module uart_tx #(
  parameter int OVERSAMPLE = 16,  // baud_clk cycles per serial bit, >= 2
  parameter int DATA_BITS  = 8,   // 5..8
  parameter int STOP_BITS  = 1,   // 1 or 2
  parameter int PARITY_ODD = 0    // only meaningful with the parity build
) (
  input  logic      baud_clk,
  input  logic      reset,        // asynchronous, active low
  uart_tx_if.slave  bus
);

  localparam int              TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]   TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
  // Only the low DATA_BITS of tx_data belong to the frame.
  localparam logic [7:0]      DMASK     = 8'((1 << DATA_BITS) - 1);

  // PARITY keeps its encoding in every build; without the parity feature
  // it is simply unreachable and recovers like any other illegal code.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Out-of-range PARITY_ODD values have no defined meaning; this guard
  // leaves an obvious marker in the elaborated hierarchy if one is used.
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
  end

  state_e          state_q, state_d;
  logic [TW-1:0]   tick_q,  tick_d;   // position inside the current bit
  logic [2:0]      bit_q,   bit_d;    // data-bit index, then stop-bit index
  logic [7:0]      shreg_q, shreg_d;  // remaining data bits, LSB goes next
  logic            dout_q,  dout_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;
  logic            tick_end;

`ifdef UART_TX_PARITY_EN
  logic            par_q,   par_d;    // parity bit, fixed at accept time
`endif

  // Next-state and output logic; every bit boundary is the edge on which
  // the tick counter sits at its last value.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    dout_d   = dout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    tick_end = (tick_q == TICK_LAST);

    // The tick counter free-runs while a frame is in flight.
    if (tick_end) tick_d = '0;
    else          tick_d = tick_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        dout_d = 1'b1;
        busy_d = 1'b0;
        if (bus.tx_start) begin
          // Accept: the start bit goes on the line from this very edge.
          state_d = ST_START;
          shreg_d = bus.tx_data & DMASK;
          dout_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d   = (^(bus.tx_data & DMASK)) ^ 1'(PARITY_ODD);
`endif
        end
      end

      ST_START: begin
        if (tick_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
          dout_d  = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end

      ST_DATA: begin
        if (tick_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            dout_d  = par_q;
`else
            state_d = ST_STOP;
            dout_d  = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            dout_d  = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_end) begin
          state_d = ST_STOP;
          bit_d   = '0;
          dout_d  = 1'b1;
        end
      end
`endif

      ST_STOP: begin
        dout_d = 1'b1;
        if (tick_end) begin
          if (bit_q == STOP_LAST) begin
            // Frame complete: drop busy and pulse done on the same edge.
            state_d = ST_IDLE;
            bit_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
          end
        end
      end

      default: begin
        // Illegal encoding: park the line high and wait for a new request.
        state_d = ST_IDLE;
        tick_d  = '0;
        bit_d   = '0;
        shreg_d = '0;
        dout_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; reset abandons any frame and returns the line high.
  always_ff @(posedge baud_clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      dout_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.dout    = dout_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx. dut1 is the default 8N1 build,
// dut2 uses two stop bits and odd parity. Bytes are pushed to a scoreboard
// when driven and popped when the matching frame is walked on the line.
module tb_uart_tx;
  localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic baud_clk = 1'b0;
  logic rst_n    = 1'b0;
  int   cyc      = 0;
  int   sel      = 1;
  int   n_run    = 0;
  int   n_fail   = 0;
  logic [7:0] sb[$];

  always #5 baud_clk = ~baud_clk;
  always @(posedge baud_clk) cyc <= cyc + 1;

  uart_tx_if if1();
  uart_tx_if if2();

  uart_tx #(.OVERSAMPLE(OS), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut1 (
    .baud_clk (baud_clk),
    .reset    (rst_n),
    .bus      (if1.slave)
  );

  uart_tx #(.OVERSAMPLE(OS), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) dut2 (
    .baud_clk (baud_clk),
    .reset    (rst_n),
    .bus      (if2.slave)
  );

  wire dout_s = (sel == 2) ? if2.dout    : if1.dout;
  wire busy_s = (sel == 2) ? if2.tx_busy : if1.tx_busy;
  wire done_s = (sel == 2) ? if2.tx_done : if1.tx_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic st, input logic [7:0] d);
    if (s == 2) begin if2.tx_start = st; if2.tx_data = d; end
    else        begin if1.tx_start = st; if1.tx_data = d; end
  endtask

  task automatic start_tx(input int s, input logic [7:0] d);
    drive(s, 1'b1, d);
    sb.push_back(d);
  endtask

  // Waits (bounded) for busy on the selected DUT; k = accept edge count.
  task automatic wait_accept(output int k);
    k = -1;
    for (int i = 0; i < 64; i++) begin
      if (busy_s === 1'b1) begin k = cyc; break; end
      @(negedge baud_clk);
    end
    check("accept_seen", 32'(k >= 0), 32'd1);
  endtask

  // Entered on the negedge right after accept edge k; walks the whole frame
  // cycle by cycle, then checks the done pulse on the negedge after the end.
  task automatic walk_frame(input int k, input int stops, input logic podd,
                            input int poke_at, input logic [7:0] poke);
    logic [7:0]  d;
    logic [15:0] samp [12];
    logic [11:0] expb;
    logic        busy_all, done_any;
    int          nb, frame;
    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    d     = sb.pop_front();
    nb    = 1 + 8 + PB + stops;
    frame = nb * OS;
    expb  = '1;
    expb[0] = 1'b0;
    for (int i = 0; i < 8; i++) expb[1 + i] = d[i];
    if (PB == 1) expb[9] = (^d) ^ podd;
    busy_all = 1'b1;
    done_any = 1'b0;
    for (int c = 0; c < frame; c++) begin
      samp[c / OS][c % OS] = dout_s;
      busy_all &= busy_s;
      done_any |= done_s;
      if (poke_at >= 0 && c == poke_at)     drive(sel, 1'b1, poke);
      if (poke_at >= 0 && c == poke_at + 1) drive(sel, 1'b0, poke);
      @(negedge baud_clk);
    end
    for (int b = 0; b < nb; b++)
      check($sformatf("frame_%02h_bit%0d", d, b), 32'(samp[b]), 32'({16{expb[b]}}));
    check("busy_in_frame", 32'(busy_all), 32'd1);
    check("no_early_done", 32'(done_any), 32'd0);
    check("done_latency",  32'(cyc - k), 32'(frame));
    check("done_pulse",    32'(done_s), 32'd1);
    check("busy_dropped",  32'(busy_s), 32'd0);
    check("line_idle",     32'(dout_s), 32'd1);
  endtask

  initial begin
    int k, k2;
    logic ok;
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);

    // Reset state.
    repeat (3) @(negedge baud_clk);
    check("rst_dout1", 32'(if1.dout),    32'd1);
    check("rst_busy1", 32'(if1.tx_busy), 32'd0);
    check("rst_done1", 32'(if1.tx_done), 32'd0);
    check("rst_dout2", 32'(if2.dout),    32'd1);
    check("rst_busy2", 32'(if2.tx_busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge baud_clk);

    // 1: single 0x55 frame.
    sel = 1;
    start_tx(1, 8'h55);
    wait_accept(k);
    drive(1, 1'b0, 8'h55);
    walk_frame(k, 1, 1'b0, -1, 8'h00);
    @(negedge baud_clk);
    check("done_one_cycle", 32'(done_s), 32'd0);

    // 2: tx_start held, 0x00 then 0xFF back-to-back.
    repeat (3) @(negedge baud_clk);
    start_tx(1, 8'h00);
    wait_accept(k);
    start_tx(1, 8'hFF);
    walk_frame(k, 1, 1'b0, -1, 8'h00);
    @(negedge baud_clk);
    k2 = cyc;
    check("b2b_busy", 32'(busy_s), 32'd1);
    check("b2b_gap",  32'(k2 - k), 32'((10 + PB) * OS + 1));
    drive(1, 1'b0, 8'hFF);
    walk_frame(k2, 1, 1'b0, -1, 8'h00);

    // 3: request mid-frame is ignored, original byte completes.
    repeat (3) @(negedge baud_clk);
    start_tx(1, 8'hA3);
    wait_accept(k);
    drive(1, 1'b0, 8'hA3);
    walk_frame(k, 1, 1'b0, 40, 8'h3C);
    ok = 1'b1;
    repeat (40) begin
      @(negedge baud_clk);
      ok &= (busy_s === 1'b0) && (done_s === 1'b0) && (dout_s === 1'b1);
    end
    check("no_queued_frame", 32'(ok), 32'd1);

    // 4: reset mid-frame.
    drive(1, 1'b1, 8'h5A);
    wait_accept(k);
    drive(1, 1'b0, 8'h5A);
    repeat (70) @(negedge baud_clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_dout", 32'(if1.dout),    32'd1);
    check("rst_mid_busy", 32'(if1.tx_busy), 32'd0);
    @(negedge baud_clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (60) begin
      @(negedge baud_clk);
      ok &= (busy_s === 1'b0) && (done_s === 1'b0) && (dout_s === 1'b1);
    end
    check("quiet_after_rst", 32'(ok), 32'd1);

    // 5: 0x07 on both builds (parity bit 1 even, 0 odd when enabled).
    start_tx(1, 8'h07);
    wait_accept(k);
    drive(1, 1'b0, 8'h07);
    walk_frame(k, 1, 1'b0, -1, 8'h00);

    // 6: two stop bits on dut2.
    sel = 2;
    repeat (3) @(negedge baud_clk);
    start_tx(2, 8'h81);
    wait_accept(k);
    drive(2, 1'b0, 8'h81);
    walk_frame(k, 2, 1'b1, -1, 8'h00);
    repeat (3) @(negedge baud_clk);
    start_tx(2, 8'h07);
    wait_accept(k);
    drive(2, 1'b0, 8'h07);
    walk_frame(k, 2, 1'b1, -1, 8'h00);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
